// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - golden-trace checker for the CPU register file
//
// Holds an expected-value table loaded before a run and compares observed
// register lanes against table[cur_idx] on every retire strobe. It counts
// failing steps, latches the first failure and reports pass/fail once the
// programmed step count has been checked.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   exp_we          table write strobe (honoured outside RUN, addr < DEPTH)
//   exp_addr        table entry to write
//   exp_wdata       expected lanes, lane k at [k*WIDTH +: WIDTH]
//   num_steps       steps to check, sampled on start (clamped to DEPTH)
//   start           begin a run (ignored while running)
//   step            one instruction retired, reg_vals valid
//   reg_vals        observed lanes, same layout as exp_wdata
//   busy, done      FSM in RUN / DONE
//   pass            run finished with no failing step (valid with done)
//   cur_idx         steps checked so far
//   err_count       failing steps, saturating
//   first_err_idx   1-based step of the first failure, 0 if none
//   first_err_mask  lanes that mismatched at the first failure
module trace_checker #(
  parameter int WIDTH = 8,
  parameter int NREGS = 2,
  parameter int DEPTH = 64,
  parameter int IDX_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   exp_we,
  input  logic [IDX_W-1:0]       exp_addr,
  input  logic [NREGS*WIDTH-1:0] exp_wdata,
  input  logic [IDX_W-1:0]       num_steps,
  input  logic                   start,
  input  logic                   step,
  input  logic [NREGS*WIDTH-1:0] reg_vals,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [IDX_W-1:0]       cur_idx,
  output logic [IDX_W-1:0]       err_count,
  output logic [IDX_W-1:0]       first_err_idx,
  output logic [NREGS-1:0]       first_err_mask
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  state_t                 stateNext;
  logic [NREGS*WIDTH-1:0] expTable [DEPTH];
  logic [NREGS*WIDTH-1:0] expRow;
  logic [IDX_W-1:0]       limit;
  logic [IDX_W-1:0]       limitSel;
  logic [IDX_W-1:0]       idxInc;
  logic [IDX_W-1:0]       errInc;
  logic [NREGS-1:0]       mismatch;
  logic                   canStart;
  logic                   stepHit;
  logic                   lastStep;

  // Table is deliberately not reset; it is only written outside a run so
  // the reference cannot shift underneath the comparison.
  always_ff @(posedge clk) begin
    if (exp_we && state != RUN && exp_addr < DEPTH_IDX) begin
      expTable[exp_addr[ADDR_W-1:0]] <= exp_wdata;
    end
  end

  // cur_idx stays below limit (<= DEPTH) while running, so the low bits
  // always address a valid entry.
  assign expRow   = expTable[cur_idx[ADDR_W-1:0]];
  assign limitSel = (num_steps > DEPTH_IDX) ? DEPTH_IDX : num_steps;
  assign canStart = start && state != RUN;
  assign stepHit  = step && state == RUN;
  assign idxInc   = cur_idx + 1'b1;
  assign lastStep = stepHit && idxInc == limit;

  always_comb begin
    mismatch = '0;
    for (int k = 0; k < NREGS; k++) begin
      mismatch[k] = reg_vals[k*WIDTH +: WIDTH] != expRow[k*WIDTH +: WIDTH];
    end
  end

  // Saturating error count including the step being checked now.
  always_comb begin
    errInc = err_count;
    if (|mismatch && err_count != '1) begin
      errInc = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext = (limitSel == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit          <= '0;
      pass           <= 1'b0;
      cur_idx        <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else if (canStart) begin
      limit          <= limitSel;
      pass           <= (limitSel == '0);
      cur_idx        <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else if (stepHit) begin
      cur_idx   <= idxInc;
      err_count <= errInc;
      if (|mismatch && first_err_idx == '0) begin
        first_err_idx  <= idxInc;
        first_err_mask <= mismatch;
      end
      if (lastStep) begin
        pass <= (errInc == '0);
      end
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed self-checking bench for trace_checker
module tb_trace_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exp_we;
  logic [6:0]  exp_addr;
  logic [15:0] exp_wdata;
  logic [6:0]  num_steps;
  logic        start;
  logic        step;
  logic [15:0] reg_vals;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  cur_idx;
  logic [6:0]  err_count;
  logic [6:0]  first_err_idx;
  logic [1:0]  first_err_mask;

  int checks = 0;
  int errors = 0;

  logic [7:0] expA [64];
  logic [7:0] expB [64];
  logic [7:0] obsA [64];
  logic [7:0] obsB [64];

  trace_checker dut (
    .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_wdata(exp_wdata), .num_steps(num_steps), .start(start), .step(step),
    .reg_vals(reg_vals), .busy(busy), .done(done), .pass(pass),
    .cur_idx(cur_idx), .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_mask(first_err_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic startRun(input int n);
    num_steps = 7'(n);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      step = 1'b1;
      reg_vals = {obsB[i], obsA[i]};
      cyc();
    end
    step = 1'b0;
  endtask

  task automatic restoreObs();
    for (int i = 0; i < 64; i++) begin
      obsA[i] = expA[i];
      obsB[i] = expB[i];
    end
  endtask

  initial begin
    rst_n = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    num_steps = '0; start = 1'b0; step = 1'b0; reg_vals = '0;

    for (int i = 0; i < 64; i++) begin
      expA[i] = 8'(42 + (i * 3) / 4);
      expB[i] = 8'(i * 7);
    end
    expB[23] = 8'h50;
    expB[56] = 8'd9;
    restoreObs();

    cyc(); cyc();
    check("reset_outputs", {busy, done, pass, cur_idx, err_count, first_err_idx, first_err_mask}, 32'h0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 64; i++) begin
      exp_we = 1'b1; exp_addr = 7'(i); exp_wdata = {expB[i], expA[i]};
      cyc();
    end
    exp_we = 1'b0;
    check("entry0_A", {24'h0, expA[0]}, 32'd42);
    check("entry56_A", {24'h0, expA[56]}, 32'd84);

    // Reset in the middle of a run.
    startRun(57);
    check("busy_after_start", busy, 1);
    feed(0, 4);
    check("mid_run_idx", cur_idx, 5);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, pass, cur_idx, err_count, first_err_idx, first_err_mask}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Zero-length run finishes on the start edge.
    startRun(0);
    check("zero_run_done_pass_busy", {done, pass, busy}, 3'b110);

    // Clean 57-step trace.
    startRun(57);
    feed(0, 55);
    check("clean_not_done_at_56", done, 0);
    feed(56, 56);
    check("clean_done_pass_busy", {done, pass, busy}, 3'b110);
    check("clean_err_count", err_count, 0);
    check("clean_first_err", first_err_idx, 0);
    check("clean_cur_idx", cur_idx, 57);

    // Single corruption on lane B at step 24.
    obsB[23] = 8'h55;
    startRun(57);
    check("restart_clears_idx", cur_idx, 0);
    feed(0, 56);
    check("single_first_idx", first_err_idx, 24);
    check("single_first_mask", first_err_mask, 2'b10);
    check("single_err_count", err_count, 1);
    check("single_done_pass", {done, pass}, 2'b10);
    restoreObs();

    // Both lanes wrong at step 3, lane A wrong at step 10.
    obsA[2] = obsA[2] ^ 8'h01;
    obsB[2] = obsB[2] ^ 8'h80;
    obsA[9] = obsA[9] + 8'd1;
    startRun(57);
    feed(0, 56);
    check("multi_first_idx", first_err_idx, 3);
    check("multi_first_mask", first_err_mask, 2'b11);
    check("multi_err_count", err_count, 2);
    check("multi_pass", pass, 0);
    restoreObs();

    // Inputs ignored while running: table write, start, idle gap.
    startRun(57);
    feed(0, 2);
    exp_we = 1'b1; exp_addr = 7'd5; exp_wdata = 16'hDEAD;
    num_steps = 7'd1; start = 1'b1;
    cyc();
    exp_we = 1'b0; start = 1'b0;
    check("start_in_run_idx", cur_idx, 3);
    check("start_in_run_busy", busy, 1);
    cyc(); cyc();
    check("idle_gap_idx", cur_idx, 3);
    feed(3, 56);
    check("ignored_inputs_done_pass", {done, pass}, 2'b11);
    check("ignored_inputs_idx", cur_idx, 57);

    // Write above DEPTH must not alias onto entry 0.
    exp_we = 1'b1; exp_addr = 7'd64; exp_wdata = 16'hBEEF;
    cyc();
    exp_we = 1'b0;
    startRun(1);
    feed(0, 0);
    check("oob_write_ignored_pass", {done, pass}, 2'b11);

    // num_steps clamped to DEPTH.
    startRun(100);
    feed(0, 62);
    check("clamp_not_done_63", {done, busy}, 2'b01);
    feed(63, 63);
    check("clamp_done_pass", {done, pass}, 2'b11);
    check("clamp_cur_idx", cur_idx, 64);

    // Restart from DONE reruns the same table.
    startRun(2);
    check("rerun_cleared", {done, pass, busy, cur_idx}, {3'b001, 7'd0});
    feed(0, 1);
    check("rerun_done_pass", {done, pass, cur_idx}, {2'b11, 7'd2});

    // Write and start together: step on a later edge sees the new entry 0.
    exp_we = 1'b1; exp_addr = 7'd0; exp_wdata = 16'h0101;
    num_steps = 7'd1; start = 1'b1;
    cyc();
    exp_we = 1'b0; start = 1'b0;
    obsA[0] = 8'h01; obsB[0] = 8'h01;
    feed(0, 0);
    check("write_with_start_pass", {done, pass}, 2'b11);
    restoreObs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
